comparador_serial_nibbles: RTL

//   Sequential driver/consumer of a 7485-style cascade interface: compares two WIDTH-bit operands
//   one 4-bit nibble per clock, LSB nibble first. Feeds each slice result back as the next slice's

---
 rtl/comparador_serial_nibbles.sv | 116 +++++++++++
 1 files changed

// File: rtl/comparador_serial_nibbles.sv
// Serial 7485-style magnitude comparator: one 4-bit slice per clock, LSB nibble first,
// with each slice result fed back as the next slice's cascade inputs.
module comparador_serial_nibbles #(
  parameter int N_NIBBLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [4*N_NIBBLES-1:0] A,
  input  logic [4*N_NIBBLES-1:0] B,
  input  logic                   cascata_maior,
  input  logic                   cascata_menor,
  input  logic                   cascata_igual,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   A_maior_que_B,
  output logic                   A_menor_que_B,
  output logic                   A_igual_a_B
);

  localparam int W     = 4 * N_NIBBLES;
  localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NIBBLES - 1);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  estado_t          estado, estado_next;
  logic [IDX_W-1:0] idx_p0;
  logic [W-1:0]     a_p0, b_p0;
  logic [W-1:0]     a_desl, b_desl;
  logic [3:0]       a_nib, b_nib;
  logic [2:0]       casc_p0, casc_next;
  logic             ultimo;

  // Cascade vectors are packed {maior, menor, igual}.
  function automatic logic [2:0] regra_igual(input logic [2:0] c);
    logic [2:0] r;
    if (c[0]) begin
      r = 3'b001;
    end else begin
      case (c[2:1])
        2'b10:   r = 3'b100;
        2'b01:   r = 3'b010;
        2'b00:   r = 3'b110;
        default: r = 3'b000;
      endcase
    end
    return r;
  endfunction

  assign a_desl  = a_p0 >> {idx_p0, 2'b00};
  assign b_desl  = b_p0 >> {idx_p0, 2'b00};
  assign a_nib   = a_desl[3:0];
  assign b_nib   = b_desl[3:0];
  assign ultimo  = (idx_p0 == IDX_LAST);
  assign ocupado = (estado == COMPARA);
  assign pronto  = (estado == FIM);

  always_comb begin
    casc_next = casc_p0;
    if (a_nib > b_nib) begin
      casc_next = 3'b100;
    end else if (a_nib < b_nib) begin
      casc_next = 3'b010;
    end else begin
      casc_next = regra_igual(casc_p0);
    end
  end

  always_comb begin
    estado_next = estado;
    case (estado)
      ESPERA:  if (iniciar) estado_next = COMPARA;
      COMPARA: if (ultimo) estado_next = FIM;
      FIM:     estado_next = ESPERA;
      default: estado_next = ESPERA;
    endcase
  end

  // Stage p0: control state, slice index and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= ESPERA;
      idx_p0        <= '0;
      A_maior_que_B <= 1'b0;
      A_menor_que_B <= 1'b0;
      A_igual_a_B   <= 1'b0;
    end else begin
      estado <= estado_next;
      if (estado == ESPERA) begin
        idx_p0 <= '0;
      end else if (estado == COMPARA && !ultimo) begin
        idx_p0 <= idx_p0 + 1'b1;
      end
      if (estado == COMPARA && ultimo) begin
        {A_maior_que_B, A_menor_que_B, A_igual_a_B} <= casc_next;
      end
    end
  end

  // Stage p0: operand capture and running cascade value
  always_ff @(posedge clock) begin
    if (estado == ESPERA && iniciar) begin
      a_p0    <= A;
      b_p0    <= B;
      casc_p0 <= {cascata_maior, cascata_menor, cascata_igual};
    end else if (estado == COMPARA) begin
      casc_p0 <= casc_next;
    end
  end

endmodule
